// File: rtl/can_pkg.sv
// ----------------------------------------------------------------------------
// can_pkg
// Shared constants for the CAN / CAN-FD receive path.
//   - Bit-destuffer state encoding (OFF, DYN, FIXED, ERR)
//   - Default stuffing lengths and the stuff-count width
// ----------------------------------------------------------------------------
package can_pkg;

   // Destuffer FSM states.
   localparam logic [1:0] ST_OFF   = 2'd0;
   localparam logic [1:0] ST_DYN   = 2'd1;
   localparam logic [1:0] ST_FIXED = 2'd2;
   localparam logic [1:0] ST_ERR   = 2'd3;

   // Equal consecutive bits that force a dynamic stuff bit.
   localparam int STUFF_LEN_DEF = 5;
   // Data bits between fixed stuff bits in the FD CRC region.
   localparam int FIXED_LEN_DEF = 4;
   // Width of the modulo stuff-bit counter.
   localparam int CNT_W_DEF     = 3;

endpackage : can_pkg

// File: rtl/bit_destuffer.sv
// ----------------------------------------------------------------------------
// bit_destuffer
// Watches the received CAN bit stream at every sample point, flags the bit
// that will be sampled next as a stuff bit so the frame controller can skip
// it, and raises a sticky error when a stuff bit has the wrong polarity.
// Handles classic dynamic stuffing, FD fixed stuffing in the CRC region and
// keeps a modulo count of accepted dynamic stuff bits.
//
// Ports
//   sp          in   sample-point clock, all updates on the rising edge
//   reset       in   asynchronous active-high reset
//   CAN_RX      in   received bus bit, valid at posedge sp
//   BS_onoff    in   destuffing enable
//   fixed_en    in   fixed-stuff mode request
//   isStuff     out  next sampled bit is a stuff bit (registered)
//   errorFlag   out  sticky stuff-rule violation (registered)
//   stuff_count out  accepted dynamic stuff bits, modulo 2^CNT_W
// ----------------------------------------------------------------------------
module bit_destuffer
   import can_pkg::*;
#(
   parameter int STUFF_LEN = STUFF_LEN_DEF,
   parameter int FIXED_LEN = FIXED_LEN_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic             sp,
   input  logic             reset,
   input  logic             CAN_RX,
   input  logic             BS_onoff,
   input  logic             fixed_en,
   output logic             isStuff,
   output logic             errorFlag,
   output logic [CNT_W-1:0] stuff_count
);

   localparam int RUN_W  = $clog2(STUFF_LEN + 1);
   localparam int FCNT_W = $clog2(FIXED_LEN + 1);

   localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(STUFF_LEN);
   localparam logic [RUN_W-1:0]  RUN_ONE  = RUN_W'(1);
   localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(FIXED_LEN);

   logic [1:0]        state_q, state_d;
   logic [RUN_W-1:0]  run_q,   run_d;
   logic              last_q,  last_d;
   logic [FCNT_W-1:0] fcnt_q,  fcnt_d;
   logic              stuff_q, stuff_d;
   logic              err_q,   err_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;

   logic [RUN_W-1:0]  run_inc;
   logic [RUN_W-1:0]  run_new;
   logic [FCNT_W-1:0] fcnt_inc;
   logic              same_bit;

   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      last_d  = last_q;
      fcnt_d  = fcnt_q;
      stuff_d = stuff_q;
      err_d   = err_q;
      cnt_d   = cnt_q;

      same_bit = (CAN_RX == last_q);
      // Run length saturates so it can never pass the stuff threshold.
      run_inc  = (run_q < RUN_MAX) ? run_q + 1'b1 : run_q;
      run_new  = same_bit ? run_inc : RUN_ONE;
      fcnt_inc = fcnt_q + 1'b1;

      if (state_q == ST_ERR) begin
         // Locked until reset; enables are ignored.
         stuff_d = 1'b0;
         err_d   = 1'b1;
      end else if (!BS_onoff) begin
         // Disable drops any pending stuff bit unchecked; count is kept.
         state_d = ST_OFF;
         stuff_d = 1'b0;
         run_d   = '0;
      end else if (state_q == ST_OFF) begin
         // The enabling edge already samples the first bit of the run.
         state_d = ST_DYN;
         run_d   = RUN_ONE;
         last_d  = CAN_RX;
         stuff_d = 1'b0;
      end else if (state_q == ST_DYN && fixed_en) begin
         // A pending dynamic stuff bit is checked here but not counted.
         if (stuff_q && same_bit) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            stuff_d = 1'b0;
         end else begin
            state_d = ST_FIXED;
            stuff_d = 1'b1;
            fcnt_d  = '0;
            last_d  = CAN_RX;
         end
      end else if (state_q == ST_FIXED && !fixed_en) begin
         state_d = ST_DYN;
         run_d   = RUN_ONE;
         last_d  = CAN_RX;
         stuff_d = 1'b0;
      end else if (state_q == ST_DYN) begin
         if (stuff_q) begin
            if (same_bit) begin
               state_d = ST_ERR;
               err_d   = 1'b1;
               stuff_d = 1'b0;
            end else begin
               // The stuff bit itself starts the next run.
               last_d  = CAN_RX;
               run_d   = RUN_ONE;
               cnt_d   = cnt_q + 1'b1;
               stuff_d = 1'b0;
            end
         end else begin
            run_d   = run_new;
            last_d  = CAN_RX;
            stuff_d = (run_new == RUN_MAX);
         end
      end else begin
         // FIXED, normal processing.
         if (stuff_q) begin
            if (same_bit) begin
               state_d = ST_ERR;
               err_d   = 1'b1;
               stuff_d = 1'b0;
            end else begin
               last_d  = CAN_RX;
               stuff_d = 1'b0;
               fcnt_d  = '0;
            end
         end else begin
            last_d  = CAN_RX;
            fcnt_d  = fcnt_inc;
            stuff_d = (fcnt_inc == FCNT_MAX);
         end
      end
   end

   always_ff @(posedge sp or posedge reset) begin
      if (reset) begin
         state_q <= ST_OFF;
         run_q   <= '0;
         last_q  <= 1'b1;
         fcnt_q  <= '0;
         stuff_q <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
         last_q  <= last_d;
         fcnt_q  <= fcnt_d;
         stuff_q <= stuff_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign isStuff     = stuff_q;
   assign errorFlag   = err_q;
   assign stuff_count = cnt_q;

endmodule : bit_destuffer
